// File: rtl/alu_muldiv_seq_pkg.sv
// Shared constants for the multiply/divide sequencer: ALU operation codes,
// the MULT/DIV op encoding and the sequencer state enum.
package alu_muldiv_seq_pkg;

  // ALU operation codes shared with the EX-stage ALU.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;

  // op[1] selects divide, op[0] selects signed.
  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NEG_A  = 3'd1,
    S_NEG_B  = 3'd2,
    S_ITER   = 3'd3,
    S_NEG_LO = 3'd4,
    S_NEG_HI = 3'd5,
    S_DONE   = 3'd6
  } md_state_e;

endpackage

// File: rtl/alu_muldiv_seq_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide. The ALU result
// (ADD(W_hi, mag_b) or SUB(s, mag_b)) arrives from the shared ALU; this
// block only does the local compares and the register shuffles.
module alu_muldiv_seq_muldiv_step #(
  parameter int W = 32
) (
  input  logic         is_div_i,
  input  logic [W-1:0] w_hi_i,
  input  logic [W-1:0] w_lo_i,
  input  logic [W-1:0] mag_b_i,
  input  logic [W-1:0] alu_result_i,
  output logic [W-1:0] s_o,
  output logic [W-1:0] w_hi_o,
  output logic [W-1:0] w_lo_o
);

  logic [W-1:0] sum;
  logic         carry;
  logic         take;

  // Next W_hi/W_lo for the selected mode.
  always_comb begin
    s_o    = {w_hi_i[W-2:0], w_lo_i[W-1]};
    sum    = w_hi_i;
    carry  = 1'b0;
    take   = 1'b0;
    w_hi_o = w_hi_i;
    w_lo_o = w_lo_i;
    if (is_div_i) begin
      // w_hi_i[W-1] set means the shifted partial remainder is >= 2^W.
      take   = w_hi_i[W-1] | (s_o >= mag_b_i);
      w_hi_o = take ? alu_result_i : s_o;
      w_lo_o = {w_lo_i[W-2:0], take};
    end else begin
      if (w_lo_i[0]) begin
        sum   = alu_result_i;
        carry = (alu_result_i < w_hi_i);
      end
      w_hi_o = {carry, sum[W-1:1]};
      w_lo_o = {sum[0], w_lo_i[W-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// MULT/MULTU/DIV/DIVU sequencer that borrows the EX-stage ALU while busy.
// Fixed latency: done rises 37 cycles after the accepted start.
// Handshake: start is a pulse honoured only in IDLE; done is a one-cycle
// pulse with hi/lo valid, and hi/lo hold until the next done or reset.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_oper,
  output logic            alu_sign,
  input  logic [XLEN-1:0] alu_result
);

  md_state_e       state_q, state_d;
  logic [XLEN-1:0] w_hi_q, w_hi_d, w_lo_q, w_lo_d, mag_b_q, mag_b_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            is_div_q, is_div_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] step_s, step_hi, step_lo;
  logic            fix_lo, fix_hi;

  alu_muldiv_seq_muldiv_step #(.W(XLEN)) u_step (
    .is_div_i    (is_div_q),
    .w_hi_i      (w_hi_q),
    .w_lo_i      (w_lo_q),
    .mag_b_i     (mag_b_q),
    .alu_result_i(alu_result),
    .s_o         (step_s),
    .w_hi_o      (step_hi),
    .w_lo_o      (step_lo)
  );

  // Sign fixups; a divide by zero keeps the raw magnitudes.
  assign fix_lo = (sa_q ^ sb_q) & ~(is_div_q & dz_q);
  assign fix_hi = is_div_q ? (sa_q & ~dz_q) : (sa_q ^ sb_q);

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign alu_sign = 1'b0;

  // Next-state, working-register updates and ALU drive.
  always_comb begin
    state_d  = state_q;
    w_hi_d   = w_hi_q;
    w_lo_d   = w_lo_q;
    mag_b_d  = mag_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    cnt_d    = cnt_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_oper = ALU_ADD;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // a parks in W_lo and b in mag_b until their magnitudes are taken.
          is_div_d = op[1];
          sa_d     = a[XLEN-1] & op[0];
          sb_d     = b[XLEN-1] & op[0];
          dz_d     = (b == '0);
          w_lo_d   = a;
          mag_b_d  = b;
          w_hi_d   = '0;
          cnt_d    = '0;
          state_d  = S_NEG_A;
        end
      end
      S_NEG_A: begin
        alu_oper = ALU_SUB;
        alu_b    = w_lo_q;
        if (sa_q) w_lo_d = alu_result;
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        alu_oper = ALU_SUB;
        alu_b    = mag_b_q;
        if (sb_q) mag_b_d = alu_result;
        w_hi_d  = '0;
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        alu_oper = is_div_q ? ALU_SUB : ALU_ADD;
        alu_a    = is_div_q ? step_s : w_hi_q;
        alu_b    = mag_b_q;
        w_hi_d   = step_hi;
        w_lo_d   = step_lo;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'(ITERS - 1)) state_d = S_NEG_LO;
      end
      S_NEG_LO: begin
        if (fix_lo) begin
          alu_oper = ALU_SUB;
          alu_b    = w_lo_q;
          w_lo_d   = alu_result;
        end
        state_d = S_NEG_HI;
      end
      S_NEG_HI: begin
        if (fix_hi) begin
          // Product HI negates by two's complement only when LO was zero;
          // otherwise the borrow from LO makes it a plain inversion.
          if (!is_div_q && (w_lo_q != '0)) begin
            alu_oper = ALU_NOR;
            alu_a    = w_hi_q;
          end else begin
            alu_oper = ALU_SUB;
            alu_b    = w_hi_q;
          end
          w_hi_d = alu_result;
        end
        hi_d    = w_hi_d;
        lo_d    = w_lo_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      w_hi_q   <= '0;
      w_lo_q   <= '0;
      mag_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      w_hi_q   <= w_hi_d;
      w_lo_q   <= w_lo_d;
      mag_b_q  <= mag_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: models the shared ALU, issues operations and
// compares hi/lo and done timing against an expected-result queue.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo, alu_a, alu_b, alu_result;
  logic [3:0]  alu_oper;
  logic        busy, done, alu_sign;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];

  alu_muldiv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_oper  (alu_oper),
    .alu_sign  (alu_sign),
    .alu_result(alu_result)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU model.
  always_comb begin
    case (alu_oper)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_XOR: alu_result = alu_a ^ alu_b;
      ALU_NOR: alu_result = ~(alu_a | alu_b);
      default: alu_result = 32'd0;
    endcase
  end

  // Reference {hi, lo} computed from magnitudes with native arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, y);
    logic        na, nb;
    logic [31:0] ma, mb, q, r;
    logic [63:0] p;
    na = o[0] & x[31];
    nb = o[0] & y[31];
    ma = na ? (32'd0 - x) : x;
    mb = nb ? (32'd0 - y) : y;
    if (!o[1]) begin
      p = {32'd0, ma} * {32'd0, mb};
      if (na ^ nb) p = 64'd0 - p;
      return p;
    end
    if (y == 32'd0) return {ma, 32'hFFFFFFFF};
    q = ma / mb;
    r = ma % mb;
    if (na ^ nb) q = 32'd0 - q;
    if (na) r = 32'd0 - r;
    return {r, q};
  endfunction

  // Drive one start pulse (called at a negedge) and queue its expectation.
  task automatic issue(input logic [1:0] o, input logic [31:0] ia, ib, input logic [63:0] exp);
    start = 1'b1;
    op = o;
    a = ia;
    b = ib;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 37);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy);
    else pass_cnt++;
  endtask

  // Wait for done, pop the scoreboard and compare; returns one cycle after done.
  task automatic sb_collect(input string name);
    logic [63:0] exp;
    int          ecyc;
    bit          seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (!seen) begin
      $display("FAIL %s_done_timeout: done not seen within 60 cycles", name);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        ecyc = exp_cyc_q.pop_front();
      end
      return;
    end
    if (exp_q.size() == 0) begin
      $display("FAIL %s_unexpected_done: done with empty queue at cycle %0d", name, cyc);
      return;
    end
    pass_cnt++;
    exp = exp_q.pop_front();
    ecyc = exp_cyc_q.pop_front();
    total_cnt++;
    if (cyc !== ecyc) $display("FAIL %s_latency: done at cycle %0d want %0d", name, cyc, ecyc);
    else pass_cnt++;
    total_cnt++;
    if (hi !== exp[63:32]) $display("FAIL %s_hi: got %h want %h", name, hi, exp[63:32]);
    else pass_cnt++;
    total_cnt++;
    if (lo !== exp[31:0]) $display("FAIL %s_lo: got %h want %h", name, lo, exp[31:0]);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_after_done: done=%b busy=%b want 0/0", name, done, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_flags: busy=%b done=%b want 0/0", busy, done);
    else pass_cnt++;
    total_cnt++;
    if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL reset_hilo: hi=%h lo=%h want 0/0", hi, lo);
    else pass_cnt++;
    total_cnt++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_oper !== ALU_ADD || alu_sign !== 1'b0)
      $display("FAIL reset_alu: a=%h b=%h oper=%h sign=%b want 0/0/%h/0", alu_a, alu_b, alu_oper, alu_sign, ALU_ADD);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    sb_collect("multu_max");
    issue(MD_MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    sb_collect("mult_neg");
    issue(MD_MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    sb_collect("mult_min");
  endtask

  task automatic test_div();
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    sb_collect("div_neg");
    issue(MD_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E);
    sb_collect("divu");
  endtask

  task automatic test_div_zero();
    issue(MD_DIVU, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF);
    sb_collect("divu_zero");
    issue(MD_DIV, 32'hFFFFFFF9, 32'd0, 64'h00000007_FFFFFFFF);
    sb_collect("div_zero_neg");
  endtask

  task automatic test_ignore_start();
    issue(MD_MULTU, 32'd1000, 32'd3000, 64'd3000000);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op = MD_DIVU;
    a = 32'd55;
    b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    sb_collect("ignored_start");
  endtask

  task automatic test_back_to_back();
    issue(MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);
    sb_collect("b2b_first");
    issue(MD_DIVU, 32'hFFFFFFFF, 32'd16, 64'h0000000F_0FFFFFFF);
    sb_collect("b2b_second");
  endtask

  task automatic test_mid_reset();
    int done_seen;
    issue(MD_MULTU, 32'hDEADBEEF, 32'h12345678, 64'd0);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_flags: busy=%b done=%b want 0/0", busy, done);
    else pass_cnt++;
    total_cnt++;
    if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL midrst_hilo: hi=%h lo=%h want 0/0", hi, lo);
    else pass_cnt++;
    exp_q.delete();
    exp_cyc_q.delete();
    done_seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    total_cnt++;
    if (done_seen != 0) $display("FAIL midrst_no_done: saw %0d done pulses want 0", done_seen);
    else pass_cnt++;
    issue(MD_DIV, 32'd7, 32'hFFFFFFFE, model(MD_DIV, 32'd7, 32'hFFFFFFFE));
    sb_collect("after_rst");
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) y = 32'($urandom_range(1, 300));
      issue(o, x, y, model(o, x, y));
      sb_collect("random");
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    a = 32'd0;
    b = 32'd0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that runs MIPS MULT/MULTU/DIV/DIVU on the shared 32-bit ALU.
- Iterates one ALU operation per cycle.
- Holds the HI/LO result registers.
- Sits beside the EX stage. While busy=1, the EX-stage operand/oper mux hands the ALU to this block.
- Fixed 37-cycle latency from the accepted start to done.

Parameters:
XLEN, 32, operand/register width (only 32 supported)
ITERS, 32, iteration count (equals XLEN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  request pulse; accepted only in IDLE
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  in  32  multiplicand / dividend (rs)
b  in  32  multiplier / divisor (rt)
busy  out  1  block owns ALU; EX mux selects alu_* below
done  out  1  one-cycle pulse, hi/lo valid
hi  out  32  HI register (product high / remainder)
lo  out  32  LO register (product low / quotient)
alu_a  out  32  ALU operand a
alu_b  out  32  ALU operand b
alu_oper  out  4  ALU operation code (shared ALU op constants)
alu_sign  out  1  always 0
alu_result  in  32  ALU result (combinational, same cycle)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0. Internal working regs are cleared.
- Reset mid-operation: abort immediately, return to IDLE, and zero hi/lo. No done pulse is produced.
- States: IDLE -> NEG_A -> NEG_B -> ITER (x32, 5-bit counter) -> NEG_LO -> NEG_HI -> DONE -> IDLE.
- IDLE:
  - start=1 latches op, a, b, and sign flags sa=a[31]&op[0], sb=b[31]&op[0].
  - start while not IDLE is ignored.
- NEG_A / NEG_B:
  - ALU SUB(0,a) then SUB(0,b) produce magnitudes.
  - The result is used only if the corresponding sign flag is set; otherwise the raw operand is used.
  - Both states always execute, so latency is fixed.
- Working registers: mag_b; W_hi=0 and W_lo=|a| are set at the end of NEG_B.
- ITER, multiply:
  - ALU ADD(W_hi, mag_b); c = (alu_result < W_hi).
  - If W_lo[0]: sum=alu_result, carry=c. Else: sum=W_hi, carry=0.
  - Update: W_hi <= {carry, sum[31:1]}; W_lo <= {sum[0], W_lo[31:1]}.
- ITER, divide (restoring):
  - s = {W_hi[30:0], W_lo[31]}; ALU SUB(s, mag_b).
  - take = W_hi[31] | (s >= mag_b), using an unsigned compare.
  - W_hi <= take ? alu_result : s; W_lo <= {W_lo[30:0], take}.
- NEG_LO / NEG_HI (fixup):
  - Multiply: if sa^sb, LO=SUB(0,W_lo); HI = (W_lo==0) ? SUB(0,W_hi) : NOR(W_hi,0).
  - Divide: LO negated (SUB) if sa^sb; HI negated (SUB) if sa.
  - Unneeded fixup cycles drive ADD(0,0) and discard the result.
- Divide by zero (b==0):
  - Fixup is skipped.
  - Result: LO=32'hFFFFFFFF, HI=|a|, where |a| is the raw a for DIVU.
- DONE: hi/lo are loaded from the working regs on entry; done=1 for exactly one cycle. hi/lo then hold until the next DONE or reset.
- Timing:
  - busy=1 in every state except IDLE.
  - done is asserted 37 cycles after the start cycle; busy deasserts the cycle after done.
  - A new start is legal in the cycle after done.
- ALU drive:
  - Outputs are combinational from state and working regs.
  - In IDLE: alu_a=alu_b=0 and alu_oper=ADD.
  - alu_sign is always 0, because all compares are done locally.

Decomposition:
- Shared package: ALU op codes (ADD, SUB, NOR, etc.), the muldiv op encoding, and the state enum.
- One natural sub-module, muldiv_step: combinational per-iteration next W_hi/W_lo given mode, alu_result and mag_b. The FSM and counter stay in the top module.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at start+37, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, normal latency.
- start pulsed at cycle 10 of an op in progress -> ignored; result and done timing match the first op only. Back-to-back start the cycle after done -> accepted.
- rst asserted at iteration 15 -> next cycle busy=0, hi=lo=0, no done pulse; a subsequent op completes correctly.
